// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline-side and memory-side bus of the shared memory port arbiter
interface mem_port_arbiter_if;
  logic        if_req;
  logic [8:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [8:0]  d_addr;
  logic [2:0]  d_func3;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_read;
  logic        mem_write;
  logic [8:0]  mem_addr;
  logic [2:0]  mem_func3;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_func3, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_read, mem_write, mem_addr, mem_func3, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_func3, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_read, mem_write, mem_addr, mem_func3, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter: data-priority with fetch starvation guard
module mem_port_arbiter #(
  parameter int unsigned INST_OFFSET = 256,
  parameter int unsigned MAX_IF_WAIT = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_port_arbiter_if.slave bus,
  output logic [15:0]       conflict_cnt_o
);

  typedef enum logic [2:0] {R_NONE, R_IF, R_LD, R_ST, R_ERR} resp_e;

  localparam logic [3:0] MaxWait = 4'(MAX_IF_WAIT);
  localparam logic [8:0] InstOff = 9'(INST_OFFSET % 512);

  logic        both_req;
  logic        force_if;
  logic        if_gnt;
  logic        d_gnt;
  logic        func3_ok;
  logic [1:0]  d_span;
  logic [9:0]  d_end;
  logic        d_reject;

  logic        mem_read;
  logic        mem_write;
  logic [8:0]  mem_addr;
  logic [2:0]  mem_func3;
  logic [31:0] mem_wdata;

  logic [3:0]  starve_q, starve_d;
  logic [15:0] conflict_q, conflict_d;
  resp_e       resp_q, resp_d;
  logic        if_rvalid_q;
  logic        d_rvalid_q;
  logic        d_err_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  // Fetch only beats a data request once it has lost MAX_IF_WAIT times in a row.
  always_comb begin
    both_req = bus.if_req & bus.d_req;
    force_if = both_req & (starve_q == MaxWait);
    d_gnt    = rst_ni & bus.d_req & ~force_if;
    if_gnt   = rst_ni & bus.if_req & ~(bus.d_req & ~force_if);
  end

  always_comb begin
    d_span   = 2'd0;
    func3_ok = 1'b0;
    case (bus.d_func3)
      3'b000: begin d_span = 2'd0; func3_ok = 1'b1;       end
      3'b001: begin d_span = 2'd1; func3_ok = 1'b1;       end
      3'b010: begin d_span = 2'd3; func3_ok = 1'b1;       end
      3'b100: begin d_span = 2'd0; func3_ok = ~bus.d_we;  end
      3'b101: begin d_span = 2'd1; func3_ok = ~bus.d_we;  end
      default: begin d_span = 2'd0; func3_ok = 1'b0;      end
    endcase
    d_end    = {1'b0, bus.d_addr} + {8'd0, d_span};
    d_reject = ~func3_ok | (d_end > 10'd511);
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 9'd0;
    mem_func3 = 3'd0;
    mem_wdata = 32'd0;
    if (if_gnt) begin
      mem_read  = 1'b1;
      mem_addr  = bus.if_addr + InstOff;
      mem_func3 = 3'b010;
    end else if (d_gnt && !d_reject) begin
      mem_addr  = bus.d_addr;
      mem_func3 = bus.d_func3;
      if (bus.d_we) begin
        mem_write = 1'b1;
        mem_wdata = bus.d_wdata;
      end else begin
        mem_read  = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || if_gnt) begin
      starve_d = 4'd0;
    end else if (both_req && d_gnt && starve_q != MaxWait) begin
      starve_d = starve_q + 4'd1;
    end

    conflict_d = conflict_q;
    if (both_req && conflict_q != 16'hFFFF) begin
      conflict_d = conflict_q + 16'd1;
    end

    resp_d = R_NONE;
    if (if_gnt) begin
      resp_d = R_IF;
    end else if (d_gnt) begin
      if (d_reject)       resp_d = R_ERR;
      else if (bus.d_we)  resp_d = R_ST;
      else                resp_d = R_LD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_q   <= 4'd0;
      conflict_q <= 16'd0;
    end else begin
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
    end
  end

  // Read data arrives from memory during the response cycle, so it is forwarded and latched then.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resp_q      <= R_NONE;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      resp_q      <= resp_d;
      if_rvalid_q <= (resp_d == R_IF);
      d_rvalid_q  <= (resp_d == R_LD) || (resp_d == R_ST) || (resp_d == R_ERR);
      d_err_q     <= (resp_d == R_ERR);
      if (resp_q == R_IF) begin
        if_rdata_q <= bus.mem_rdata;
      end
      if (resp_q == R_LD) begin
        d_rdata_q <= bus.mem_rdata;
      end else if (resp_q == R_ST || resp_q == R_ERR) begin
        d_rdata_q <= 32'd0;
      end
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_func3 = mem_func3;
  assign bus.mem_wdata = mem_wdata;

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = (resp_q == R_IF) ? bus.mem_rdata : if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = (resp_q == R_LD) ? bus.mem_rdata :
                         (d_rvalid_q ? 32'd0 : d_rdata_q);

  assign conflict_cnt_o = conflict_q;

endmodule
